// File: rtl/nlc_pkg.sv
// Shared types and widths for the NLC sample driver.
package nlc_pkg;

    localparam int unsigned SAMPLE_W = 21;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } drv_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port, occupancy count and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    assign count = count_q;
    // Drive zero while empty so the head never shows stale or uninitialised storage.
    assign rdata = empty ? '0 : mem_q[rptr_q];

    // Accept/pop qualification and pointer/count next state.
    always_comb begin
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = rptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset since empty gates the read port.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/nlc_sample_driver.sv
// Feeds buffered ADC codes to the NLC one at a time and collects its results.
// Only one sample is ever in flight; a result slot is reserved before issue.
module nlc_sample_driver
    import nlc_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    output logic                wr_full,
    input  logic                rd_en,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                rd_empty,
    output logic                srdyi,
    output logic [SAMPLE_W-1:0] x_adc,
    input  logic                srdyo,
    input  logic [SAMPLE_W-1:0] x_lin,
    output logic                busy,
    output logic                timeout_err,
    input  logic                clr_err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned TmrW = 16;

    drv_state_t          state_q, state_d;
    logic                srdyi_q, srdyi_d;
    logic [SAMPLE_W-1:0] x_adc_q, x_adc_d;
    logic [TmrW-1:0]     tmr_q, tmr_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [SAMPLE_W-1:0] smp_rdata;
    logic                smp_empty, smp_pop;
    logic [CntW-1:0]     smp_count_unused;
    logic [CntW-1:0]     res_count;
    logic                res_full_unused;
    logic                res_push;

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_smp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .wdata (wr_data),
        .pop   (smp_pop),
        .rdata (smp_rdata),
        .count (smp_count_unused),
        .full  (wr_full),
        .empty (smp_empty)
    );

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (res_push),
        .wdata (x_lin),
        .pop   (rd_en),
        .rdata (rd_data),
        .count (res_count),
        .full  (res_full_unused),
        .empty (rd_empty)
    );

    // Transaction sequencing, timeout counting and sticky error next state.
    always_comb begin
        state_d  = state_q;
        srdyi_d  = 1'b0;
        x_adc_d  = x_adc_q;
        tmr_d    = tmr_q;
        err_d    = err_q;
        smp_pop  = 1'b0;
        res_push = 1'b0;
        // Clear first so a timeout in the same cycle overrides it.
        if (clr_err) err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!smp_empty && ((32'(res_count) + 32'd1) <= DEPTH)) begin
                    state_d = StIssue;
                    smp_pop = 1'b1;
                    x_adc_d = smp_rdata;
                    srdyi_d = 1'b1;
                end
            end
            StIssue: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (srdyo) begin
                    res_push = 1'b1;
                    state_d  = StIdle;
                end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                    tmr_d   = TmrW'(TIMEOUT);
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            srdyi_q <= 1'b0;
            x_adc_q <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            srdyi_q <= srdyi_d;
            x_adc_q <= x_adc_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign srdyi       = srdyi_q;
    assign x_adc       = x_adc_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_nlc_sample_driver.sv
// Directed bench for nlc_sample_driver with a simple NLC responder model.
module tb_nlc_sample_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [20:0] wr_data;
    logic        wr_full;
    logic        rd_en;
    logic [20:0] rd_data;
    logic        rd_empty;
    logic        srdyi;
    logic [20:0] x_adc;
    logic        srdyo = 1'b0;
    logic [20:0] x_lin = '0;
    logic        busy;
    logic        timeout_err;
    logic        clr_err;

    int n_checks = 0;
    int n_errors = 0;

    // Responder controls (written by the stimulus block only).
    bit          model_on  = 1'b1;
    bit          model_xor = 1'b0;
    int          lat       = 5;
    bit          man_req   = 1'b0;
    logic [20:0] man_data  = '0;

    // Responder state (written by the responder only).
    bit          pend        = 1'b0;
    int          cnt         = 0;
    logic [20:0] resp_data   = '0;
    int          n_srdyi     = 0;
    int          overlap_err = 0;

    logic [20:0] burst_v [10];
    logic [20:0] bp_v [9];

    nlc_sample_driver #(
        .DEPTH   (8),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_empty    (rd_empty),
        .srdyi       (srdyi),
        .x_adc       (x_adc),
        .srdyo       (srdyo),
        .x_lin       (x_lin),
        .busy        (busy),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    // NLC model: updates just after each rising edge, answers lat cycles after srdyi.
    always @(posedge clk) begin
        #1;
        srdyo = 1'b0;
        if (!busy) pend = 1'b0;
        if (srdyi) begin
            n_srdyi++;
            if (pend) overlap_err++;
            pend      = 1'b1;
            cnt       = lat;
            resp_data = model_xor ? (x_adc ^ 21'h155555) : 21'h1FFFFF;
        end else if (pend && model_on) begin
            if (cnt <= 1) begin
                srdyo = 1'b1;
                x_lin = resp_data;
                pend  = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (man_req) begin
            srdyo = 1'b1;
            x_lin = man_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [20:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_srdyi(input int target, input int budget, input string tag);
        int k = 0;
        while (n_srdyi < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, n_srdyi, target);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_result(input int budget, input string tag);
        int k = 0;
        while (rd_empty !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, rd_empty}, 32'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_srdyi"}, {31'd0, srdyi}, 32'd0);
        check({pfx, "_x_adc"}, {11'd0, x_adc}, 32'd0);
        check({pfx, "_wr_full"}, {31'd0, wr_full}, 32'd0);
        check({pfx, "_rd_empty"}, {31'd0, rd_empty}, 32'd1);
        check({pfx, "_rd_data"}, {11'd0, rd_data}, 32'd0);
        check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        check({pfx, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        for (int i = 0; i < 10; i++) burst_v[i] = 21'(32'h0A5A5 + i * 32'h11357);
        for (int i = 0; i < 9; i++) bp_v[i] = 21'(32'h1F0000 - i * 32'h00321);

        // Reset state.
        tick(3);
        check_reset_values("rst");
        reset = 1'b1;
        tick(2);

        // Single sample: strobe one cycle after the push edge, result shows ahead.
        push(21'h001234);
        check("single_srdyi_early", {31'd0, srdyi}, 32'd0);
        tick(1);
        check("single_srdyi", {31'd0, srdyi}, 32'd1);
        check("single_x_adc", {11'd0, x_adc}, 32'h001234);
        check("single_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("single_srdyi_pulse", {31'd0, srdyi}, 32'd0);
        check("single_x_adc_hold", {11'd0, x_adc}, 32'h001234);
        wait_result(20, "single_result_ready");
        check("single_rd_data", {11'd0, rd_data}, 32'h1FFFFF);
        check("single_idle_after", {31'd0, busy}, 32'd0);
        pop();
        check("single_rd_empty", {31'd0, rd_empty}, 32'd1);
        check("single_rd_data_zero", {11'd0, rd_data}, 32'd0);

        // Burst: one slow transaction in flight, then ten writes into an 8-deep FIFO.
        model_xor = 1'b1;
        lat       = 12;
        push(21'h0ABCDE);
        wait_srdyi(2, 10, "burst_prime_issue");
        for (int i = 0; i < 10; i++) begin
            push(burst_v[i]);
            if (i < 7) check("burst_not_full", {31'd0, wr_full}, 32'd0);
            else       check("burst_full", {31'd0, wr_full}, 32'd1);
        end
        wait_result(40, "burst_prime_ready");
        check("burst_prime_data", {11'd0, rd_data}, {11'd0, 21'h0ABCDE ^ 21'h155555});
        pop();
        wait_srdyi(10, 300, "burst_issue_count");
        wait_idle(40, "burst_idle");
        tick(5);
        check("burst_no_extra_issue", n_srdyi, 10);
        for (int i = 0; i < 8; i++) begin
            check("burst_result", {11'd0, rd_data}, {11'd0, burst_v[i] ^ 21'h155555});
            pop();
        end
        check("burst_drained", {31'd0, rd_empty}, 32'd1);
        check("burst_wr_full_clear", {31'd0, wr_full}, 32'd0);

        // Back-pressure: no reads, so only eight results may complete.
        lat = 3;
        for (int i = 0; i < 9; i++) push(bp_v[i]);
        wait_srdyi(18, 200, "bp_issue_count");
        tick(20);
        check("bp_stalled_count", n_srdyi, 18);
        check("bp_srdyi_low", {31'd0, srdyi}, 32'd0);
        check("bp_busy_low", {31'd0, busy}, 32'd0);
        check("bp_head", {11'd0, rd_data}, {11'd0, bp_v[0] ^ 21'h155555});
        pop();
        wait_srdyi(19, 20, "bp_release_one");
        wait_idle(20, "bp_release_idle");
        tick(10);
        check("bp_release_exactly_one", n_srdyi, 19);

        // Push and pop on the result FIFO in the same cycle as srdyo.
        model_on = 1'b0;
        push(21'h055AA5);
        pop();
        wait_srdyi(20, 10, "pp_issue");
        man_data = 21'h0F0F0F;
        man_req  = 1'b1;
        @(negedge clk);
        man_req  = 1'b0;
        rd_en    = 1'b1;
        @(negedge clk);
        rd_en    = 1'b0;
        check("pp_busy", {31'd0, busy}, 32'd0);
        for (int i = 3; i < 9; i++) begin
            check("pp_order", {11'd0, rd_data}, {11'd0, bp_v[i] ^ 21'h155555});
            pop();
        end
        check("pp_last", {11'd0, rd_data}, 32'h0F0F0F);
        pop();
        check("pp_count_kept", {31'd0, rd_empty}, 32'd1);

        // Timeout: no answer, error rises 16 cycles after entering WAIT.
        push(21'h1C0DE0);
        tick(17);
        check("to_err_before", {31'd0, timeout_err}, 32'd0);
        check("to_busy_before", {31'd0, busy}, 32'd1);
        tick(1);
        check("to_err_set", {31'd0, timeout_err}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_no_push", {31'd0, rd_empty}, 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("to_err_cleared", {31'd0, timeout_err}, 32'd0);
        man_data = 21'h123456;
        man_req  = 1'b1;
        tick(1);
        man_req  = 1'b0;
        tick(2);
        check("stray_srdyo_ignored", {31'd0, rd_empty}, 32'd1);

        // Timeout with clr_err held: setting the flag wins.
        clr_err = 1'b1;
        push(21'h000777);
        tick(17);
        check("tow_err_held_clear", {31'd0, timeout_err}, 32'd0);
        tick(1);
        check("tow_set_wins", {31'd0, timeout_err}, 32'd1);
        clr_err = 1'b0;
        tick(1);
        check("tow_sticky", {31'd0, timeout_err}, 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("tow_cleared", {31'd0, timeout_err}, 32'd0);

        // Reset during WAIT, then a late srdyo.
        model_on = 1'b1;
        lat      = 5;
        push(21'h0BEEF0);
        tick(1);
        check("rw_srdyi", {31'd0, srdyi}, 32'd1);
        tick(2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        man_data = 21'h0AAAAA;
        man_req  = 1'b1;
        tick(1);
        man_req  = 1'b0;
        tick(3);
        check_reset_values("rw");
        check("rw_no_reissue", n_srdyi, 23);

        check("no_overlapping_srdyi", overlap_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
